// File: rtl/alu_mc.sv
// Multi-cycle execute unit: single-cycle RV32I ALU plus an iterative radix-2
// multiply/divide engine, with valid/ready handshakes on both sides.
module alu_mc #(
  parameter int D_WIDTH = 32,
  parameter int EN_MD   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               alusrc,
  input  logic [3:0]         aluctrl,
  input  logic               md_en,
  input  logic [2:0]         md_op,
  input  logic [D_WIDTH-1:0] aluop1,
  input  logic [D_WIDTH-1:0] immop,
  input  logic [D_WIDTH-1:0] regop2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] aluout,
  output logic               eq
);

  localparam int SHW = $clog2(D_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic                 alive_q;
  logic [SHW-1:0]       cnt_q;
  logic [2:0]           op_q;
  logic [D_WIDTH-1:0]   m_q, hi_q, lo_q, aluout_q;
  logic                 neg_q, rneg_q, divz_q, eq_q;

  logic [D_WIDTH-1:0]   op2_s, a_mag_s, b_mag_s, alu_res_d, hi_d, lo_d;
  logic [D_WIDTH-1:0]   quo_s, rem_s, md_res_d;
  logic [SHW-1:0]       shamt_s;
  logic [D_WIDTH:0]     mul_sum_s, div_sh_s, div_diff_s;
  logic [2*D_WIDTH-1:0] prod_s;
  logic                 accept_s, alu_eq_d, a_sgn_s, b_sgn_s, sa_s, sb_s;

  assign op2_s     = alusrc ? immop : regop2;
  assign shamt_s   = op2_s[SHW-1:0];
  // alive_q keeps in_ready low until the first edge after reset release
  assign in_ready  = rst_n && alive_q &&
                     ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign accept_s  = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign aluout    = aluout_q;
  assign eq        = eq_q;

  always_comb begin
    alu_res_d = '0;
    case (aluctrl)
      4'b0000: alu_res_d = aluop1 + op2_s;
      4'b1000: alu_res_d = aluop1 - op2_s;
      4'b0001: alu_res_d = aluop1 << shamt_s;
      4'b0101: alu_res_d = aluop1 >> shamt_s;
      4'b1101: alu_res_d = $unsigned($signed(aluop1) >>> shamt_s);
      4'b0100: alu_res_d = aluop1 ^ op2_s;
      4'b0110: alu_res_d = aluop1 | op2_s;
      4'b0111: alu_res_d = aluop1 & op2_s;
      4'b0010: alu_res_d = {{(D_WIDTH-1){1'b0}}, ($signed(aluop1) < $signed(op2_s))};
      4'b0011: alu_res_d = {{(D_WIDTH-1){1'b0}}, (aluop1 < op2_s)};
      default: alu_res_d = '0;
    endcase
    alu_eq_d = (aluctrl == 4'b0100) ? (alu_res_d != '0) : alu_res_d[0];
  end

  // The engine works on magnitudes; signs are reapplied when the op finishes
  always_comb begin
    a_sgn_s = (md_op == 3'd0) || (md_op == 3'd1) || (md_op == 3'd2) ||
              (md_op == 3'd4) || (md_op == 3'd6);
    b_sgn_s = (md_op == 3'd0) || (md_op == 3'd1) || (md_op == 3'd4) ||
              (md_op == 3'd6);
    sa_s    = a_sgn_s && aluop1[D_WIDTH-1];
    sb_s    = b_sgn_s && op2_s[D_WIDTH-1];
    a_mag_s = sa_s ? ('0 - aluop1) : aluop1;
    b_mag_s = sb_s ? ('0 - op2_s) : op2_s;
  end

  // One shift-add or restoring-subtract step, plus the sign-corrected result
  always_comb begin
    mul_sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    div_sh_s   = {hi_q, lo_q[D_WIDTH-1]};
    div_diff_s = div_sh_s - {1'b0, m_q};
    if (op_q[2]) begin
      if (!div_diff_s[D_WIDTH]) begin
        hi_d = div_diff_s[D_WIDTH-1:0];
        lo_d = {lo_q[D_WIDTH-2:0], 1'b1};
      end else begin
        hi_d = div_sh_s[D_WIDTH-1:0];
        lo_d = {lo_q[D_WIDTH-2:0], 1'b0};
      end
    end else begin
      {hi_d, lo_d} = {mul_sum_s, lo_q[D_WIDTH-1:1]};
    end
    prod_s = neg_q ? ('0 - {hi_d, lo_d}) : {hi_d, lo_d};
    quo_s  = divz_q ? '1 : (neg_q ? ('0 - lo_d) : lo_d);
    rem_s  = rneg_q ? ('0 - hi_d) : hi_d;
    case (op_q)
      3'd0:                md_res_d = prod_s[D_WIDTH-1:0];
      3'd1, 3'd2, 3'd3:    md_res_d = prod_s[2*D_WIDTH-1:D_WIDTH];
      3'd4, 3'd5:          md_res_d = quo_s;
      default:             md_res_d = rem_s;
    endcase
  end

  // Control FSM, operand latches and registered outputs
  always_ff @(posedge clk) begin
    alive_q <= rst_n;
    if (!rst_n) begin
      state_q  <= S_IDLE;
      aluout_q <= '0;
      eq_q     <= 1'b0;
      cnt_q    <= '0;
      op_q     <= 3'd0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept_s) begin
            if (md_en) begin
              if (EN_MD != 0) begin
                state_q <= S_BUSY;
                cnt_q   <= '0;
                op_q    <= md_op;
                hi_q    <= '0;
                m_q     <= md_op[2] ? b_mag_s : a_mag_s;
                lo_q    <= md_op[2] ? a_mag_s : b_mag_s;
                neg_q   <= sa_s ^ sb_s;
                rneg_q  <= sa_s;
                divz_q  <= (op2_s == '0);
              end else begin
                state_q  <= S_DONE;
                aluout_q <= '0;
                eq_q     <= 1'b0;
              end
            end else begin
              state_q  <= S_DONE;
              aluout_q <= alu_res_d;
              eq_q     <= alu_eq_d;
            end
          end else if ((state_q == S_DONE) && out_ready) begin
            state_q <= S_IDLE;
          end
        end
        S_BUSY: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + SHW'(1);
          if (&cnt_q) begin
            aluout_q <= md_res_d;
            eq_q     <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases, randomized ops against a
// behavioural model, backpressure, back-to-back issue and mid-op reset.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, alusrc, md_en, out_valid, out_ready, eq;
  logic [3:0]  aluctrl;
  logic [2:0]  md_op;
  logic [31:0] aluop1, immop, regop2, aluout;

  int n_checks = 0;
  int n_errors = 0;

  alu_mc #(.D_WIDTH(32), .EN_MD(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alusrc(alusrc), .aluctrl(aluctrl), .md_en(md_en), .md_op(md_op),
    .aluop1(aluop1), .immop(immop), .regop2(regop2), .out_valid(out_valid),
    .out_ready(out_ready), .aluout(aluout), .eq(eq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU: returns {eq, result}
  function automatic logic [32:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    int sh;
    sh = int'(b % 32);
    case (c)
      4'd0:  r = a + b;
      4'd8:  r = a - b;
      4'd1:  r = a << sh;
      4'd5:  r = a >> sh;
      4'd13: begin
        r = a >> sh;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      4'd4:  r = a ^ b;
      4'd6:  r = a | b;
      4'd7:  r = a & b;
      4'd2:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd3:  r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {(c == 4'd4) ? (r != 32'd0) : r[0], r};
  endfunction

  // Reference M-extension result using 64-bit and native integer arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic as, bs, ovf;
    as  = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    bs  = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    ea  = as ? {{32{a[31]}}, a} : {32'd0, a};
    eb  = bs ? {{32{b[31]}}, b} : {32'd0, b};
    p   = ea * eb;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0:    return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4:    return (b == 32'd0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(int'(a) / int'(b));
      3'd5:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6:    return (b == 32'd0) ? a : ovf ? 32'd0 : 32'(int'(a) % int'(b));
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic md, input logic [3:0] ctrl,
                        input logic [2:0] mop, input logic [31:0] a, input logic [31:0] imm,
                        input logic [31:0] r2, input logic src, input logic [31:0] exp_res,
                        input logic exp_eq, input int exp_lat);
    int n;
    @(negedge clk);
    md_en = md; aluctrl = ctrl; md_op = mop; aluop1 = a; immop = imm; regop2 = r2;
    alusrc = src; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        in_valid = 1'b0; aluop1 = $urandom; immop = $urandom; regop2 = $urandom;
        md_op = 3'($urandom); aluctrl = 4'($urandom);
      end
    end while (!out_valid && n < 200);
    check({tag, ".latency"}, 64'(n), 64'(exp_lat));
    check({tag, ".aluout"}, 64'(aluout), 64'(exp_res));
    check({tag, ".eq"}, 64'(eq), 64'(exp_eq));
  endtask

  task automatic alu_t(input string tag, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] imm, input logic [31:0] r2, input logic src);
    logic [32:0] e;
    e = ref_alu(c, a, src ? imm : r2);
    run_op(tag, 1'b0, c, 3'd0, a, imm, r2, src, e[31:0], e[32], 1);
  endtask

  task automatic md_t(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    run_op(tag, 1'b1, 4'd0, op, a, $urandom, b, 1'b0, ref_md(op, a, b), 1'b0, 33);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [32:0] e, prev;
    logic [31:0] held;
    int seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; alusrc = 1'b0; md_en = 1'b0;
    aluctrl = 4'd0; md_op = 3'd0; aluop1 = 32'd0; immop = 32'd0; regop2 = 32'd0;
    repeat (3) @(negedge clk);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.aluout", 64'(aluout), 64'd0);
    check("rst.eq", 64'(eq), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel.in_ready", 64'(in_ready), 64'd1);

    // Directed cases
    run_op("add", 1'b0, 4'b0000, 3'd0, 32'd5, 32'd0, 32'd7, 1'b0, 32'd12, 1'b0, 1);
    run_op("slt", 1'b0, 4'b0010, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 32'd1, 1'b1, 1);
    run_op("sltu", 1'b0, 4'b0011, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 32'd0, 1'b0, 1);
    run_op("sra", 1'b0, 4'b1101, 3'd0, 32'h8000_0000, 32'd0, 32'h24, 1'b0, 32'hF800_0000, 1'b0, 1);
    run_op("xor_eq", 1'b0, 4'b0100, 3'd0, 32'h10, 32'd0, 32'h30, 1'b0, 32'h20, 1'b1, 1);
    run_op("bad_ctrl", 1'b0, 4'b1111, 3'd0, 32'h5, 32'd0, 32'h3, 1'b0, 32'd0, 1'b0, 1);
    run_op("mulh", 1'b1, 4'd0, 3'd1, 32'h8000_0000, 32'd0, 32'd2, 1'b0, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("div0", 1'b1, 4'd0, 3'd4, 32'd7, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("rem0", 1'b1, 4'd0, 3'd6, 32'd7, 32'd0, 32'd0, 1'b0, 32'd7, 1'b0, 33);
    run_op("divovf", 1'b1, 4'd0, 3'd4, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0, 33);
    run_op("divu", 1'b1, 4'd0, 3'd5, 32'd100, 32'd0, 32'd7, 1'b0, 32'd14, 1'b0, 33);
    run_op("remneg", 1'b1, 4'd0, 3'd6, 32'hFFFF_FFF9, 32'd0, 32'd2, 1'b0, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("mulhsu", 1'b1, 4'd0, 3'd2, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 33);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++)
      alu_t("rnd_alu", 4'($urandom), pick(), $urandom, pick(), 1'($urandom));
    for (int i = 0; i < 24; i++)
      md_t("rnd_md", 3'($urandom), pick(), pick());

    // Backpressure: result held, no acceptance while out_ready is low
    @(negedge clk);
    md_en = 1'b0; aluctrl = 4'b1000; aluop1 = 32'd3; regop2 = 32'd10; alusrc = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp.out_valid", 64'(out_valid), 64'd1);
      check("bp.aluout", 64'(aluout), 64'hFFFF_FFF9);
      check("bp.in_ready", 64'(in_ready), 64'd0);
      aluop1 = $urandom; regop2 = $urandom; aluctrl = 4'($urandom);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp.drain", 64'(out_valid), 64'd0);

    // Back-to-back ALU issue: one result per cycle
    prev = 33'd0;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("b2b.out_valid", 64'(out_valid), 64'd1);
        check("b2b.aluout", 64'(aluout), 64'(prev[31:0]));
        check("b2b.eq", 64'(eq), 64'(prev[32]));
      end
      if (i < 8) begin
        md_en = 1'b0; aluctrl = 4'($urandom); aluop1 = pick(); regop2 = pick();
        immop = $urandom; alusrc = 1'($urandom); in_valid = 1'b1; out_ready = 1'b1;
        prev = ref_alu(aluctrl, aluop1, alusrc ? immop : regop2);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);

    // Reset in the middle of a divide discards it
    md_en = 1'b1; md_op = 3'd5; aluop1 = 32'd1000; regop2 = 32'd3; alusrc = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst.out_valid", 64'(out_valid), 64'd0);
    check("midrst.aluout", 64'(aluout), 64'd0);
    check("midrst.in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    check("midrst.rel_pre", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("midrst.rel_post", 64'(in_ready), 64'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst.no_result", 64'(seen), 64'd0);
    held = 32'hFFFF_FF9C;
    md_t("post_rst_div", 3'd4, held, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
